gpio_handoff_ctrl: RTL and testbench
====================================

# gpio_handoff_ctrl

Sequences ownership changes of the 38 shared GPIO pins between the management core (team 0) and NUM_TEAMS design teams. Holds the per-pin owner-select table that drives the GPIO output/oeb mux, and performs each handoff glitch-free. The handoff forces the pin to input (oeb high) for a guard interval, then switches the select, then releases the pin. It sits between the configuration source (Wishbone register front-end) and the GPIO mux select inputs.

## Interface
- NUM_TEAMS, 12, number of design teams; owner IDs 0..NUM_TEAMS are legal, 0 = management.
- SEL_W, 4, owner-ID width; must satisfy 2^SEL_W > NUM_TEAMS.
- GUARD_CYCLES, 4, tristate guard length in cycles, 8-bit range; 0 is treated as 1.
- clk  in  1  system clock; all state changes on the rising edge.
- nrst  in  1  synchronous, active-low reset.
- req_valid  in  1  handoff request valid.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_pin  in  6  target pin, legal 0..37.
- req_team  in  SEL_W  new owner ID.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on a rejected request.
- pin_sel_flat  out  38*SEL_W  owner table; pin p occupies bits [p*SEL_W +: SEL_W].
- force_oeb  out  38  per-pin override; the mux ORs this into the pin's oeb.
- lock_mask  in  38  present only with GPIO_HANDOFF_LOCK_EN; 1 = pin locked.

## Operation
- States: IDLE, GUARD, SWITCH, DONE, ERR.
- On acceptance, req_pin and req_team are latched. Later changes on the request inputs have no effect until the next acceptance.
- Error check at acceptance, in priority order:
  - req_pin > 37 → ERR.
  - req_team > NUM_TEAMS → ERR.
  - Pin locked (macro builds only) → ERR.
- No-op: if the request is legal and req_team already equals the pin's current owner → DONE directly. No tristate is applied and the table is not written.
- Normal handoff:
  - IDLE → GUARD. force_oeb[pin]=1 and the guard counter loads the effective guard length.
  - GUARD holds for the effective guard length, then → SWITCH.
  - SWITCH: force_oeb[pin]=1; the table entry is written with the latched team at the end of the cycle; → DONE.
  - DONE: force_oeb[pin]=0, done=1; → IDLE.
  - ERR: err=1, nothing modified; → IDLE.
- Only the latched pin's force bit is ever set; all other force_oeb bits stay 0.
- Table entries for all other pins never change during a handoff.
- Reset values (nrst low at a clock edge):
  - state=IDLE, req_ready=1, busy=0, done=0, err=0.
  - force_oeb=0.
  - All pin_sel_flat entries = 0.
- Reset mid-handoff: the same values apply on the next edge and the in-flight request is discarded.

## Timing
- Acceptance edge = cycle 0. With G = max(GUARD_CYCLES,1):
  - Cycles 1..G: GUARD.
  - Cycle G+1: SWITCH; the new select is visible from cycle G+2.
  - Cycle G+2: DONE; done=1, force_oeb=0.
  - Cycle G+3: IDLE, req_ready=1.
- Invariant: force_oeb[pin] is high on the cycle before and the cycle of the select change. The old and new owners never drive simultaneously.
- No-op and error requests: DONE or ERR in cycle 1, IDLE in cycle 2.
- Back-to-back: the earliest next acceptance is at the edge ending the first IDLE cycle after DONE/ERR. req_ready is 0 from cycle 1 through the DONE/ERR cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- GPIO_HANDOFF_LOCK_EN defined:
  - The lock_mask port exists.
  - lock_mask is sampled at acceptance; a locked pin → ERR and the table is unchanged.
  - Deasserting the lock bit mid-handoff does not affect an in-flight request.
- GPIO_HANDOFF_LOCK_EN undefined:
  - The lock_mask port is absent.
  - There is no lock check; all other behaviour is identical.

## Test plan
- Reset then idle: nrst low for 2 cycles → pin_sel_flat=0, force_oeb=0, req_ready=1, busy=0, done=0, err=0.
- Normal handoff, GUARD_CYCLES=4: request pin 5 → team 3.
  - force_oeb[5]=1 in cycles 1–5.
  - Select for pin 5 becomes 3 at cycle 6.
  - done=1 in cycle 6, req_ready=1 in cycle 7.
  - All other fields unchanged.
- No-op and range errors:
  - Pin 5 → team 3 again: done in cycle 1, force_oeb stays 0.
  - Pin 40: err in cycle 1.
  - Team 13 with NUM_TEAMS=12: err in cycle 1.
  - The table is unchanged in every case.
- Reset mid-handoff: assert nrst in cycle 3 of a pin 0 → team 7 handoff → next edge gives IDLE, force_oeb=0, all selects 0, no done pulse.
- GUARD_CYCLES=0: pin 37 → team 12 → force_oeb[37] high in cycles 1–2, done in cycle 3.
  - Back-to-back pin 36 → team 1 accepted at the first IDLE cycle completes normally.
- Lock (macro defined): lock_mask[10]=1, request pin 10 → team 2 → err in cycle 1, select unchanged.
  - Clear the lock and repeat → done at cycle G+2.

Source files
------------

// File: rtl/gpio_handoff_ctrl.sv
// Glitch-free ownership handoff sequencer for the 38 shared GPIO pins.
// Optional per-pin lock check is enabled by defining GPIO_HANDOFF_LOCK_EN.
module gpio_handoff_ctrl #(
    parameter int unsigned NUM_TEAMS    = 12,
    parameter int unsigned SEL_W        = 4,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [5:0]          req_pin,
    input  logic [SEL_W-1:0]    req_team,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [38*SEL_W-1:0] pin_sel_flat,
    output logic [37:0]         force_oeb
`ifdef GPIO_HANDOFF_LOCK_EN
    ,
    input  logic [37:0]         lock_mask
`endif
);

    localparam int unsigned      NUM_PINS = 38;
    localparam logic [5:0]       MAX_PIN  = 6'd37;
    localparam logic [SEL_W-1:0] MAX_TEAM = SEL_W'(NUM_TEAMS);
    localparam logic [7:0]       G_EFF    = (GUARD_CYCLES == 0) ? 8'd1 : 8'(GUARD_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        GUARD,
        SWITCH,
        DONE,
        ERR
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         pin_q, pin_d;
    logic [SEL_W-1:0]   team_q, team_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q [NUM_PINS];
    logic [SEL_W-1:0]   sel_d [NUM_PINS];

    logic               pin_bad;
    logic               team_bad;
    logic               locked;
    logic [SEL_W-1:0]   cur_owner;

    // Request checks, evaluated against the live inputs at acceptance only.
    always_comb begin
        pin_bad   = (req_pin > MAX_PIN);
        team_bad  = (req_team > MAX_TEAM);
        cur_owner = '0;
        locked    = 1'b0;
        for (int unsigned p = 0; p < NUM_PINS; p++) begin
            if (req_pin == 6'(p)) begin
                cur_owner = sel_q[p];
`ifdef GPIO_HANDOFF_LOCK_EN
                locked    = lock_mask[p];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            pin_q   <= '0;
            team_q  <= '0;
            cnt_q   <= '0;
            for (int unsigned p = 0; p < NUM_PINS; p++) begin
                sel_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            pin_q   <= pin_d;
            team_q  <= team_d;
            cnt_q   <= cnt_d;
            for (int unsigned p = 0; p < NUM_PINS; p++) begin
                sel_q[p] <= sel_d[p];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pin_d   = pin_q;
        team_d  = team_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pin_d  = req_pin;
                    team_d = req_team;
                    if (pin_bad || team_bad || locked) begin
                        state_d = ERR;
                    end else if (req_team == cur_owner) begin
                        state_d = DONE;
                    end else begin
                        state_d = GUARD;
                        cnt_d   = G_EFF;
                    end
                end
            end
            GUARD: begin
                if (cnt_q <= 8'd1) begin
                    state_d = SWITCH;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SWITCH:  state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The select only changes at the end of SWITCH, while the pin is still forced to input.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PINS; p++) begin
            sel_d[p] = sel_q[p];
            if (state_q == SWITCH && pin_q == 6'(p)) begin
                sel_d[p] = team_q;
            end
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        err       = (state_q == ERR);
        force_oeb = '0;
        for (int unsigned p = 0; p < NUM_PINS; p++) begin
            if ((state_q == GUARD || state_q == SWITCH) && pin_q == 6'(p)) begin
                force_oeb[p] = 1'b1;
            end
            pin_sel_flat[p*SEL_W +: SEL_W] = sel_q[p];
        end
    end

endmodule

// File: tb/tb_gpio_handoff_ctrl.sv
// Directed bench for gpio_handoff_ctrl: one instance with a 4-cycle guard, one with a 0 guard.
module tb_gpio_handoff_ctrl;

    localparam int K_NORM = 0;
    localparam int K_NOOP = 1;
    localparam int K_ERR  = 2;

    logic         clk = 1'b0;
    logic         nrst;
    logic         va, vb;
    logic [5:0]   req_pin;
    logic [3:0]   req_team;
    logic         a_ready, a_busy, a_done, a_err;
    logic         b_ready, b_busy, b_done, b_err;
    logic [151:0] a_sel, b_sel;
    logic [37:0]  a_force, b_force;
`ifdef GPIO_HANDOFF_LOCK_EN
    logic [37:0]  lock_mask;
`endif

    always #5 clk = ~clk;

    gpio_handoff_ctrl #(.NUM_TEAMS(12), .SEL_W(4), .GUARD_CYCLES(4)) dut_a (
        .clk(clk), .nrst(nrst), .req_valid(va), .req_ready(a_ready),
        .req_pin(req_pin), .req_team(req_team), .busy(a_busy), .done(a_done),
        .err(a_err), .pin_sel_flat(a_sel), .force_oeb(a_force)
`ifdef GPIO_HANDOFF_LOCK_EN
        , .lock_mask(lock_mask)
`endif
    );

    gpio_handoff_ctrl #(.NUM_TEAMS(12), .SEL_W(4), .GUARD_CYCLES(0)) dut_b (
        .clk(clk), .nrst(nrst), .req_valid(vb), .req_ready(b_ready),
        .req_pin(req_pin), .req_team(req_team), .busy(b_busy), .done(b_done),
        .err(b_err), .pin_sel_flat(b_sel), .force_oeb(b_force)
`ifdef GPIO_HANDOFF_LOCK_EN
        , .lock_mask(lock_mask)
`endif
    );

    bit           use_b;
    logic         cur_ready, cur_busy, cur_done, cur_err;
    logic [151:0] cur_sel;
    logic [37:0]  cur_force;

    always_comb begin
        cur_ready = use_b ? b_ready : a_ready;
        cur_busy  = use_b ? b_busy  : a_busy;
        cur_done  = use_b ? b_done  : a_done;
        cur_err   = use_b ? b_err   : a_err;
        cur_sel   = use_b ? b_sel   : a_sel;
        cur_force = use_b ? b_force : a_force;
    end

    int checks = 0;
    int errors = 0;
    logic [3:0] mdl [2][38];

    typedef struct {
        logic [5:0] pin;
        logic [3:0] team;
        int         kind;
        logic [3:0] owner_after;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [151:0] act, input logic [151:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [151:0] flat(input int d);
        logic [151:0] f;
        f = '0;
        for (int p = 0; p < 38; p++) f[p*4 +: 4] = mdl[d][p];
        return f;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 38; p++) mdl[d][p] = 4'd0;
    endtask

    // Called away from the rising edge with the selected DUT in IDLE; returns at the
    // falling edge of the first IDLE cycle afterwards, so calls can run back to back.
    task automatic run_req(input logic [5:0] pin, input logic [3:0] team, input int kind,
                           input int g, input logic [3:0] owner_after);
        int           d;
        int           last;
        logic [151:0] old_flat, new_flat, exp_tab;
        logic [37:0]  oh, exp_force;
        logic         exp_ready, exp_done, exp_err;
        string        tag;
        d        = use_b ? 1 : 0;
        old_flat = flat(d);
        oh       = (pin < 6'd38) ? (38'd1 << pin) : '0;
        req_pin  = pin;
        req_team = team;
        if (use_b) vb = 1'b1; else va = 1'b1;
        @(posedge clk);
        #1;
        va = 1'b0;
        vb = 1'b0;
        req_pin  = ~pin;
        req_team = ~team;
        if (kind == K_NORM) mdl[d][pin] = team;
        new_flat = flat(d);
        last = (kind == K_NORM) ? g + 3 : 2;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            tag       = $sformatf("dut%0d pin%0d team%0d c%0d", d, pin, team, c);
            exp_ready = (c == last);
            exp_done  = (kind != K_ERR) && (c == last - 1);
            exp_err   = (kind == K_ERR) && (c == 1);
            exp_force = (kind == K_NORM && c <= g + 1) ? oh : '0;
            exp_tab   = (kind == K_NORM && c >= g + 2) ? new_flat : old_flat;
            check({tag, " ready"}, 152'(cur_ready), 152'(exp_ready));
            check({tag, " busy"},  152'(cur_busy),  152'(!exp_ready));
            check({tag, " done"},  152'(cur_done),  152'(exp_done));
            check({tag, " err"},   152'(cur_err),   152'(exp_err));
            check({tag, " force"}, 152'(cur_force), 152'(exp_force));
            check({tag, " table"}, cur_sel, exp_tab);
        end
        if (pin < 6'd38)
            check($sformatf("dut%0d owner pin%0d", d, pin), 152'(cur_sel[int'(pin)*4 +: 4]),
                  152'(owner_after));
    endtask

    initial begin
        vecs[0] = '{6'd5,  4'd3,  K_NORM, 4'd3};
        vecs[1] = '{6'd5,  4'd3,  K_NOOP, 4'd3};
        vecs[2] = '{6'd40, 4'd3,  K_ERR,  4'd0};
        vecs[3] = '{6'd5,  4'd13, K_ERR,  4'd3};
        vecs[4] = '{6'd9,  4'd12, K_NORM, 4'd12};
        vecs[5] = '{6'd9,  4'd0,  K_NORM, 4'd0};
        vecs[6] = '{6'd37, 4'd0,  K_NOOP, 4'd0};
        vecs[7] = '{6'd63, 4'd1,  K_ERR,  4'd0};
        vecs[8] = '{6'd0,  4'd15, K_ERR,  4'd0};
        vecs[9] = '{6'd20, 4'd12, K_NORM, 4'd12};

        clear_model();
        use_b    = 1'b0;
        nrst     = 1'b0;
        va       = 1'b0;
        vb       = 1'b0;
        req_pin  = '0;
        req_team = '0;
`ifdef GPIO_HANDOFF_LOCK_EN
        lock_mask = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset a ready", 152'(a_ready), 152'(1'b1));
        check("reset a busy",  152'(a_busy),  152'(1'b0));
        check("reset a done",  152'(a_done),  152'(1'b0));
        check("reset a err",   152'(a_err),   152'(1'b0));
        check("reset a force", 152'(a_force), 152'(0));
        check("reset a table", a_sel, 152'(0));
        check("reset b ready", 152'(b_ready), 152'(1'b1));
        check("reset b force", 152'(b_force), 152'(0));
        check("reset b table", b_sel, 152'(0));
        nrst = 1'b1;

        for (int i = 0; i < 10; i++)
            run_req(vecs[i].pin, vecs[i].team, vecs[i].kind, 4, vecs[i].owner_after);

        // Reset during the guard interval of a pin 0 -> team 7 handoff.
        req_pin  = 6'd0;
        req_team = 4'd7;
        va       = 1'b1;
        @(posedge clk);
        #1;
        va = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst force before", 152'(a_force), 152'(38'd1));
        nrst = 1'b0;
        @(negedge clk);
        check("midrst ready", 152'(a_ready), 152'(1'b1));
        check("midrst busy",  152'(a_busy),  152'(1'b0));
        check("midrst done",  152'(a_done),  152'(1'b0));
        check("midrst force", 152'(a_force), 152'(0));
        check("midrst table", a_sel, 152'(0));
        nrst = 1'b1;
        clear_model();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("midrst idle done c%0d", c), 152'(a_done), 152'(1'b0));
            check($sformatf("midrst idle ready c%0d", c), 152'(a_ready), 152'(1'b1));
        end

        // Zero guard length behaves as one cycle; second request is back to back.
        use_b = 1'b1;
        run_req(6'd37, 4'd12, K_NORM, 1, 4'd12);
        run_req(6'd36, 4'd1,  K_NORM, 1, 4'd1);
        use_b = 1'b0;

`ifdef GPIO_HANDOFF_LOCK_EN
        lock_mask = 38'd1 << 10;
        run_req(6'd10, 4'd2, K_ERR, 4, 4'd0);
        lock_mask = '0;
        run_req(6'd10, 4'd2, K_NORM, 4, 4'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
